// File: rtl/axi_read_error_responder.sv
// axi_read_error_responder: answers a decoder-rejected AR with a full
// DECERR burst on R, then pulses error_gnt_o to release the decoder.
// Ports: clk, rst (sync, active-high); AR capture sample_ardata_info_i,
//   arid_i, arlen_i, aruser_i; outstanding_trans_i drain qualifier;
//   error_gnt_o grant; R channel rvalid_o/rready_i/rid_o/rdata_o/rresp_o/
//   rlast_o/ruser_o; busy_o (not IDLE).
// Option: define AXI_ERR_RDATA_PATTERN_EN to drive 32'hBADACCE5 on rdata_o
//   (replicated); otherwise rdata_o is all zeros.
module axi_read_error_responder #(
   parameter int AXI_ID_WIDTH   = 6,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_USER_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      sample_ardata_info_i,
   input  logic [AXI_ID_WIDTH-1:0]   arid_i,
   input  logic [7:0]                arlen_i,
   input  logic [AXI_USER_WIDTH-1:0] aruser_i,
   input  logic                      outstanding_trans_i,
   output logic                      error_gnt_o,
   output logic                      rvalid_o,
   input  logic                      rready_i,
   output logic [AXI_ID_WIDTH-1:0]   rid_o,
   output logic [AXI_DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]                rresp_o,
   output logic                      rlast_o,
   output logic [AXI_USER_WIDTH-1:0] ruser_o,
   output logic                      busy_o
);

   typedef enum logic [1:0] {
      IDLE,
      DRAIN,
      SEND,
      DONE
   } state_t;

`ifdef AXI_ERR_RDATA_PATTERN_EN
   localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA =
      {(AXI_DATA_WIDTH/32){32'hBADACCE5}};
`else
   localparam logic [AXI_DATA_WIDTH-1:0] ERR_DATA = '0;
`endif

   state_t                    state_q;
   logic [7:0]                cnt_q;
   logic [AXI_ID_WIDTH-1:0]   id_q;
   logic [AXI_USER_WIDTH-1:0] user_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
         user_q  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (sample_ardata_info_i) begin
                  id_q    <= arid_i;
                  user_q  <= aruser_i;
                  cnt_q   <= arlen_i;
                  state_q <= DRAIN;
               end
            end
            DRAIN: begin
               if (!outstanding_trans_i) begin
                  state_q <= SEND;
               end
            end
            SEND: begin
               // cnt_q holds beats remaining minus one; the zero beat is last
               if (rready_i) begin
                  if (cnt_q == 8'd0) begin
                     state_q <= DONE;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Everything below is decoded from registers only
   assign rvalid_o    = (state_q == SEND);
   assign rlast_o     = (state_q == SEND) && (cnt_q == 8'd0);
   assign error_gnt_o = (state_q == DONE);
   assign busy_o      = (state_q != IDLE);
   assign rid_o       = id_q;
   assign ruser_o     = user_q;
   assign rdata_o     = ERR_DATA;
   assign rresp_o     = 2'b11;

endmodule

// File: tb/tb_axi_read_error_responder.sv
// tb_axi_read_error_responder: scoreboard bench for the read error
// responder; expected beats are queued at request time, popped per beat.
module tb_axi_read_error_responder;

   typedef struct packed {
      logic [5:0] id;
      logic [5:0] user;
      logic       last;
   } beat_t;

`ifdef AXI_ERR_RDATA_PATTERN_EN
   localparam logic [63:0] EXP_DATA = 64'hBADACCE5BADACCE5;
`else
   localparam logic [63:0] EXP_DATA = 64'h0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sample_ardata_info_i = 1'b0;
   logic [5:0]  arid_i = '0;
   logic [7:0]  arlen_i = '0;
   logic [5:0]  aruser_i = '0;
   logic        outstanding_trans_i = 1'b0;
   logic        error_gnt_o;
   logic        rvalid_o;
   logic        rready_i = 1'b1;
   logic [5:0]  rid_o;
   logic [63:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o;
   logic [5:0]  ruser_o;
   logic        busy_o;

   int    total = 0;
   int    bad = 0;
   int    cyc = 0;
   int    hs_cnt = 0;
   int    gnt_cnt = 0;
   int    last_hs_cyc = 0;
   bit    rdy_mode = 1'b0;
   bit    stall_q = 1'b0;
   beat_t stall_b;
   logic [63:0] stall_d;
   beat_t sb[$];

   axi_read_error_responder dut (
      .clk                  (clk),
      .rst                  (rst),
      .sample_ardata_info_i (sample_ardata_info_i),
      .arid_i               (arid_i),
      .arlen_i              (arlen_i),
      .aruser_i             (aruser_i),
      .outstanding_trans_i  (outstanding_trans_i),
      .error_gnt_o          (error_gnt_o),
      .rvalid_o             (rvalid_o),
      .rready_i             (rready_i),
      .rid_o                (rid_o),
      .rdata_o              (rdata_o),
      .rresp_o              (rresp_o),
      .rlast_o              (rlast_o),
      .ruser_o              (ruser_o),
      .busy_o               (busy_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      #1;
      rready_i = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // R channel monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (rst) begin
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check("stall_valid", rvalid_o, 1);
            check("stall_id", rid_o, stall_b.id);
            check("stall_last", rlast_o, stall_b.last);
            check("stall_data", rdata_o, stall_d);
         end
         if (rvalid_o && rready_i) begin
            hs_cnt++;
            if (sb.size() == 0) begin
               check("extra_beat", 1, 0);
            end else begin
               beat_t e;
               e = sb.pop_front();
               check("rid", rid_o, e.id);
               check("ruser", ruser_o, e.user);
               check("rlast", rlast_o, e.last);
               check("rresp", rresp_o, 2'b11);
               check("rdata", rdata_o, EXP_DATA);
               if (e.last) last_hs_cyc = cyc;
            end
         end
         if (error_gnt_o) begin
            gnt_cnt++;
            check("gnt_timing", cyc, last_hs_cyc + 1);
         end
         stall_q = rvalid_o && !rready_i;
         stall_b = '{id: rid_o, user: ruser_o, last: rlast_o};
         stall_d = rdata_o;
      end
   end

   task automatic send_req(input logic [5:0] id, input logic [7:0] len,
                           input logic [5:0] user);
      check("idle_before_req", busy_o, 0);
      for (int i = 0; i <= int'(len); i++) begin
         sb.push_back('{id: id, user: user, last: (i == int'(len))});
      end
      arid_i = id;
      arlen_i = len;
      aruser_i = user;
      sample_ardata_info_i = 1'b1;
      @(posedge clk);
      #1;
      sample_ardata_info_i = 1'b0;
   endtask

   task automatic wait_gnt(input int target, input int budget);
      int n;
      n = 0;
      while (gnt_cnt < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (gnt_cnt < target) begin
         check("gnt_timeout", gnt_cnt, target);
         sb.delete();
      end
      @(posedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n;
      n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge clk);
         #2;
         n++;
      end
      if (hs_cnt < target) check("hs_timeout", hs_cnt, target);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int h0;
      int g0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_rvalid", rvalid_o, 0);
      check("rst_rlast", rlast_o, 0);
      check("rst_gnt", error_gnt_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_rid", rid_o, 0);
      check("rst_ruser", ruser_o, 0);
      check("rst_rdata", rdata_o, EXP_DATA);
      check("rst_rresp", rresp_o, 2'b11);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // single beat, minimum latency
      h0 = hs_cnt;
      send_req(6'h15, 8'd0, 6'h2);
      @(negedge clk);
      check("lat_n1", rvalid_o, 0);
      @(negedge clk);
      check("lat_n2", rvalid_o, 1);
      wait_gnt(1, 20);
      check("single_beats", hs_cnt - h0, 1);
      check("single_gnt", gnt_cnt, 1);

      // drain wait
      h0 = hs_cnt;
      outstanding_trans_i = 1'b1;
      send_req(6'h0a, 8'd1, 6'h11);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("drain_quiet", rvalid_o, 0);
      end
      @(posedge clk);
      #1;
      outstanding_trans_i = 1'b0;
      @(negedge clk);
      check("drain_hold", rvalid_o, 0);
      @(negedge clk);
      check("drain_rise", rvalid_o, 1);
      wait_gnt(2, 20);
      check("drain_beats", hs_cnt - h0, 2);

      // backpressure
      h0 = hs_cnt;
      rdy_mode = 1'b1;
      send_req(6'h33, 8'd3, 6'h3c);
      @(posedge clk);
      #1;
      outstanding_trans_i = 1'b1;
      wait_gnt(3, 200);
      outstanding_trans_i = 1'b0;
      rdy_mode = 1'b0;
      check("bp_beats", hs_cnt - h0, 4);
      check("bp_gnt", gnt_cnt, 3);

      // maximum length
      h0 = hs_cnt;
      send_req(6'h3f, 8'd255, 6'h15);
      wait_gnt(4, 400);
      check("max_beats", hs_cnt - h0, 256);
      repeat (3) @(posedge clk);
      #1;
      check("max_no_extra", rvalid_o, 0);

      // reset mid-burst
      h0 = hs_cnt;
      g0 = gnt_cnt;
      send_req(6'h2a, 8'd7, 6'h07);
      wait_hs(h0 + 2, 40);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("mid_rvalid", rvalid_o, 0);
      check("mid_busy", busy_o, 0);
      check("mid_beats", hs_cnt - h0, 2);
      sb.delete();
      repeat (4) @(posedge clk);
      #1;
      check("mid_no_gnt", gnt_cnt, g0);

      h0 = hs_cnt;
      send_req(6'h05, 8'd1, 6'h09);
      wait_gnt(5, 20);
      check("post_beats", hs_cnt - h0, 2);
      check("final_gnt", gnt_cnt, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
